pc_unit: RTL and testbench

//   Parametrised program counter for the pipelined CPU fetch stage. Sequential

---
 rtl/pc_unit.sv | 122 ++++++++++++
 tb/tb_pc_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with stall hold and redirect buffer.
// Optional trap redirect to TRAP_VEC enabled by `define PC_TRAP_EN.
module pc_unit #(
  parameter int              PC_W      = 32,
  parameter int              STEP      = 4,
  parameter int              ALIGN_B   = 2,
  parameter logic [PC_W-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [PC_W-1:0] TRAP_VEC  = 32'h0000_0080,
  parameter int              CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [PC_W-1:0]  redirect_pc_i,
  input  logic             trap_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             pc_valid_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [PC_W-1:0] LOW_M =
    (PC_W'(1) << ALIGN_B) - PC_W'(1);
  localparam logic [PC_W-1:0] INC = PC_W'(STEP);

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  rd_pc;
  logic             live;
  logic             trap_hit;

  assign rd_pc = redirect_pc_i & ~LOW_M;
  assign live  = (state_q != S_IDLE);

`ifdef PC_TRAP_EN
  assign trap_hit = trap_i & live;
`else
  logic [PC_W:0] unused_trap;
  assign unused_trap = {trap_i, TRAP_VEC};
  assign trap_hit    = 1'b0;
`endif

  // Next-state: trap, then per-state redirect/stall/increment priority.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (live && !stall_i && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
    if (trap_hit) begin
      pc_d    = TRAP_VEC;
      tgt_d   = '0;
      state_d = S_RUN;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i)
            state_d = S_RUN;
        end
        S_RUN: begin
          if (!start_i) begin
            state_d = S_IDLE;
            tgt_d   = '0;
          end else if (redirect_valid_i && stall_i) begin
            tgt_d   = rd_pc;
            state_d = S_HOLD;
          end else if (redirect_valid_i) begin
            pc_d = rd_pc;
          end else if (!stall_i) begin
            pc_d = pc_q + INC;
          end
        end
        S_HOLD: begin
          if (!start_i) begin
            state_d = S_IDLE;
            tgt_d   = '0;
          end else if (!stall_i) begin
            pc_d    = redirect_valid_i ? rd_pc : tgt_q;
            tgt_d   = '0;
            state_d = S_RUN;
          end else if (redirect_valid_i) begin
            tgt_d = rd_pc;
          end
        end
        default: begin
          state_d = S_IDLE;
          tgt_d   = '0;
        end
      endcase
    end
  end

  // State registers; async reset drops any buffered redirect.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_VEC;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = live;
  assign pending_o   = (state_q == S_HOLD);
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table plus wrap, saturation
// and async-reset sequences for pc_unit.
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        rst_w_n;
  logic        start;
  logic        stall;
  logic        rv;
  logic [31:0] rpc;
  logic        trap;

  logic [31:0] pc;
  logic        vld;
  logic        pnd;
  logic [15:0] cnt;

  logic [31:0] pc_w;
  logic        vld_w;
  logic        pnd_w;
  logic [1:0]  cnt_w;

  int n_cmp = 0;
  int n_bad = 0;

  pc_unit u_dut (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .start_i          (start),
    .stall_i          (stall),
    .redirect_valid_i (rv),
    .redirect_pc_i    (rpc),
    .trap_i           (trap),
    .pc_o             (pc),
    .pc_valid_o       (vld),
    .pending_o        (pnd),
    .fetch_cnt_o      (cnt)
  );

  pc_unit #(
    .RESET_VEC (32'hFFFF_FFFC),
    .CNT_W     (2)
  ) u_wrap (
    .clk_i            (clk),
    .rst_i            (rst_w_n),
    .start_i          (start),
    .stall_i          (stall),
    .redirect_valid_i (rv),
    .redirect_pc_i    (rpc),
    .trap_i           (trap),
    .pc_o             (pc_w),
    .pc_valid_o       (vld_w),
    .pending_o        (pnd_w),
    .fetch_cnt_o      (cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        sl;
    logic        rv;
    logic [31:0] rpc;
    logic        tr;
    logic [31:0] pc;
    logic        vl;
    logic        pd;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, input logic sl,
                     input logic r, input logic [31:0] rp,
                     input logic tr, input logic [31:0] p,
                     input logic vl, input logic pd,
                     input logic [15:0] c);
    vec_t v;
    v.st = st; v.sl = sl; v.rv = r; v.rpc = rp; v.tr = tr;
    v.pc = p; v.vl = vl; v.pd = pd; v.cnt = c;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rst_w_n = 1'b0;
    start = 1'b0; stall = 1'b0; rv = 1'b0;
    rpc = '0; trap = 1'b0;

    // start sequence and increment
    add(1,0,0,32'h0,0, 32'h00,1,0,0);
    add(1,0,0,32'h0,0, 32'h04,1,0,1);
    add(1,0,0,32'h0,0, 32'h08,1,0,2);
    add(1,0,0,32'h0,0, 32'h0C,1,0,3);
    add(1,0,0,32'h0,0, 32'h10,1,0,4);
    add(1,0,0,32'h0,0, 32'h14,1,0,5);
    add(1,0,0,32'h0,0, 32'h18,1,0,6);
    add(1,0,0,32'h0,0, 32'h1C,1,0,7);
    add(1,0,0,32'h0,0, 32'h20,1,0,8);
    // plain stall
    add(1,1,0,32'h0,0, 32'h20,1,0,8);
    add(1,1,0,32'h0,0, 32'h20,1,0,8);
    add(1,1,0,32'h0,0, 32'h20,1,0,8);
    add(1,0,0,32'h0,0, 32'h24,1,0,9);
    // unstalled redirect, misaligned target
    add(1,0,1,32'h103,0, 32'h100,1,0,10);
    add(1,0,0,32'h0,0,   32'h104,1,0,11);
    // buffered redirect, latest wins
    add(1,1,1,32'h200,0, 32'h104,1,1,11);
    add(1,1,1,32'h302,0, 32'h104,1,1,11);
    add(1,1,0,32'h0,0,   32'h104,1,1,11);
    add(1,0,0,32'h0,0,   32'h300,1,0,12);
    add(1,0,0,32'h0,0,   32'h304,1,0,13);
    // release with same-cycle redirect
    add(1,1,1,32'h400,0, 32'h304,1,1,13);
    add(1,0,1,32'h500,0, 32'h500,1,0,14);
    add(1,0,0,32'h0,0,   32'h504,1,0,15);
    // stop while holding, IDLE ignores redirect
    add(1,1,1,32'h600,0, 32'h504,1,1,15);
    add(0,1,0,32'h0,0,   32'h504,0,0,15);
    add(0,0,1,32'h700,0, 32'h504,0,0,15);
    add(1,0,0,32'h0,0,   32'h504,1,0,15);
    add(1,0,0,32'h0,0,   32'h508,1,0,16);
    // trap under stall
    add(1,0,1,32'h40,0,  32'h40,1,0,17);
`ifdef PC_TRAP_EN
    add(1,1,0,32'h0,1,   32'h80,1,0,17);
    add(1,0,0,32'h0,0,   32'h84,1,0,18);
`else
    add(1,1,0,32'h0,1,   32'h40,1,0,17);
    add(1,0,0,32'h0,0,   32'h44,1,0,18);
`endif

    #3;
    chk("rst pc",  pc,  32'h0);
    chk("rst vld", {31'b0, vld}, 32'h0);
    chk("rst pnd", {31'b0, pnd}, 32'h0);
    chk("rst cnt", {16'b0, cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      start = vq[i].st; stall = vq[i].sl;
      rv = vq[i].rv; rpc = vq[i].rpc; trap = vq[i].tr;
      step();
      chk($sformatf("v%0d pc", i),  pc, vq[i].pc);
      chk($sformatf("v%0d vld", i), {31'b0, vld},
          {31'b0, vq[i].vl});
      chk($sformatf("v%0d pnd", i), {31'b0, pnd},
          {31'b0, vq[i].pd});
      chk($sformatf("v%0d cnt", i), {16'b0, cnt},
          {16'b0, vq[i].cnt});
    end

    // wrap and counter saturation on second instance
    @(negedge clk);
    rst_w_n = 1'b1;
    start = 1'b1; stall = 1'b0; rv = 1'b0; trap = 1'b0;
    step();
    chk("w0 pc", pc_w, 32'hFFFF_FFFC);
    chk("w0 vld", {31'b0, vld_w}, 32'h1);
    step();
    chk("w1 pc wrap", pc_w, 32'h0);
    chk("w1 cnt", {30'b0, cnt_w}, 32'h1);
    step();
    step();
    chk("w3 pc", pc_w, 32'h8);
    chk("w3 cnt", {30'b0, cnt_w}, 32'h3);
    step();
    chk("w4 pc", pc_w, 32'hC);
    chk("w4 cnt sat", {30'b0, cnt_w}, 32'h3);

    // async reset while holding a buffered redirect
    stall = 1'b1; rv = 1'b1; rpc = 32'h40;
    step();
    chk("wh pnd", {31'b0, pnd_w}, 32'h1);
    chk("wh pc", pc_w, 32'hC);
    rv = 1'b0;
    #2;
    rst_w_n = 1'b0;
    #1;
    chk("ar pc",  pc_w, 32'hFFFF_FFFC);
    chk("ar vld", {31'b0, vld_w}, 32'h0);
    chk("ar pnd", {31'b0, pnd_w}, 32'h0);
    chk("ar cnt", {30'b0, cnt_w}, 32'h0);
    @(negedge clk);
    rst_w_n = 1'b1;
    stall = 1'b0;
    step();
    chk("ap pc",  pc_w, 32'hFFFF_FFFC);
    chk("ap pnd", {31'b0, pnd_w}, 32'h0);
    step();
    chk("ap pc2", pc_w, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
